// File: rtl/odometry_pkg.sv
// Shared types and constants for the differential-drive odometry engine.
// Holds the control FSM encoding and the counter saturation limit.
package odometry_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        DIVIDE,
        UPDATE
    } odo_state_e;

    localparam int MRAD_SCALE = 1000;

    function automatic int cnt_sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/odometry_integrator_if.sv
// Result bus of the odometry engine: per-window deltas, pose and status.
// The engine drives the master side; navigation logic reads the slave side.
interface odometry_integrator_if #(
    parameter int DIST_W = 32
);
    logic signed [DIST_W-1:0] delta_left;
    logic signed [DIST_W-1:0] delta_right;
    logic signed [DIST_W-1:0] average_distance;
    logic signed [DIST_W-1:0] delta_theta;
    logic signed [DIST_W-1:0] theta;
    logic                     odom_valid;
    logic                     busy;
    logic                     overflow;

    modport master (
        output delta_left, delta_right, average_distance,
        output delta_theta, theta, odom_valid, busy, overflow
    );

    modport slave (
        input delta_left, delta_right, average_distance,
        input delta_theta, theta, odom_valid, busy, overflow
    );
endinterface

// File: rtl/seq_signed_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, DIV_W cycles.
// Divides the magnitude, then re-applies the sign (truncate toward zero).
module seq_signed_divider #(
    parameter int DIV_W = 48
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_start,
    input  logic signed [DIV_W-1:0] i_dividend,
    input  logic        [DIV_W-1:0] i_divisor,
    output logic                    o_done,
    output logic signed [DIV_W-1:0] o_quotient
);
    localparam int CW = $clog2(DIV_W + 1);

    logic [DIV_W-1:0] r_rem;
    logic [DIV_W-1:0] r_quo;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;
    logic [DIV_W-1:0] w_abs;
    logic [DIV_W:0]   w_sh;
    logic [DIV_W:0]   w_diff;

    assign w_abs  = i_dividend[DIV_W-1] ? -i_dividend : i_dividend;
    assign w_sh   = {r_rem, r_quo[DIV_W-1]};
    assign w_diff = w_sh - {1'b0, i_divisor};
    // high in the cycle whose edge retires the last quotient bit
    assign o_done = (r_cnt == CW'(1));
    assign o_quotient = r_neg ? -$signed(r_quo) : $signed(r_quo);

    // load on start, then shift/subtract until the bit counter empties
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
            r_neg <= 1'b0;
        end else if (i_start) begin
            r_rem <= '0;
            r_quo <= w_abs;
            r_cnt <= CW'(DIV_W);
            r_neg <= i_dividend[DIV_W-1];
        end else if (r_cnt != '0) begin
            if (!w_diff[DIV_W]) begin
                r_rem <= w_diff[DIV_W-1:0];
                r_quo <= {r_quo[DIV_W-2:0], 1'b1};
            end else begin
                r_rem <= w_sh[DIV_W-1:0];
                r_quo <= {r_quo[DIV_W-2:0], 1'b0};
            end
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/wheel_edge_decoder.sv
// One wheel: sync + debounce of A/B, rising-A decode, saturating count.
// An edge landing on the window wrap seeds the fresh window.
module wheel_edge_decoder
    import odometry_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int INVERT          = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_a,
    input  logic                    i_b,
    input  logic                    i_enable,
    input  logic                    i_wrap,
    output logic signed [CNT_W-1:0] o_count,
    output logic                    o_sat
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic signed [CNT_W-1:0] C_MAX = CNT_W'(cnt_sat_max(CNT_W));
    localparam logic signed [CNT_W-1:0] C_MIN = -C_MAX;
    localparam logic signed [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [1:0]              r_s1;
    logic [1:0]              r_s2;
    logic [1:0]              r_db;
    logic [DBW-1:0]          r_dbc [2];
    logic                    r_a_q;
    logic signed [CNT_W-1:0] r_count;
    logic                    r_sat;
    logic                    w_edge;
    logic                    w_up;

    assign w_edge  = i_enable & r_db[0] & ~r_a_q;
    assign w_up    = (INVERT != 0) ? r_db[1] : ~r_db[1];
    assign o_count = r_count;
    assign o_sat   = r_sat;

    // two-flop synchroniser for {B, A}
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= {i_b, i_a};
            r_s2 <= r_s1;
        end
    end

    // accept a new level only after DEBOUNCE_CYCLES equal samples
    always_ff @(posedge clk) begin
        if (reset) begin
            r_db     <= '0;
            r_dbc[0] <= '0;
            r_dbc[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] == r_db[i]) begin
                    r_dbc[i] <= '0;
                end else if (r_dbc[i] == DB_LAST) begin
                    r_db[i]  <= r_s2[i];
                    r_dbc[i] <= '0;
                end else begin
                    r_dbc[i] <= r_dbc[i] + DBW'(1);
                end
            end
        end
    end

    // previous debounced A for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) r_a_q <= 1'b0;
        else       r_a_q <= r_db[0];
    end

    // saturating per-window pulse counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_sat <= 1'b0;
            if (i_wrap) begin
                if (w_edge) r_count <= w_up ? C_ONE : -C_ONE;
                else        r_count <= '0;
            end else if (w_edge) begin
                if (w_up) begin
                    if (r_count == C_MAX) r_sat <= 1'b1;
                    else                  r_count <= r_count + C_ONE;
                end else begin
                    if (r_count == C_MIN) r_sat <= 1'b1;
                    else                  r_count <= r_count - C_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/odometry_integrator.sv
// Differential-drive odometry: windowed wheel counts to distance,
// heading change and a wrapped absolute heading.
module odometry_integrator
    import odometry_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter int DIST_W          = 32,
    parameter int DIST_PER_PULSE  = 628,
    parameter int WHEEL_BASE      = 200,
    parameter int PERIOD_CYCLES   = 50000,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DIV_W           = 48,
    parameter int PI_MRAD         = 3142,
    parameter int INVERT_LEFT     = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic A_left,
    input  logic B_left,
    input  logic A_right,
    input  logic B_right,
    input  logic enable,
    input  logic clear_pose,
    odometry_integrator_if.master o_odom
);
    localparam int TW = $clog2(PERIOD_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(PERIOD_CYCLES - 1);
    localparam logic signed [DIV_W-1:0] K_DPP  = DIV_W'(DIST_PER_PULSE);
    localparam logic signed [DIV_W-1:0] K_MRAD = DIV_W'(MRAD_SCALE);
    localparam logic signed [DIV_W-1:0] K_PI_Q = DIV_W'(PI_MRAD);
    localparam logic        [DIV_W-1:0] K_WB   = DIV_W'(WHEEL_BASE);
    localparam logic signed [DIST_W:0]  K_PI_T = (DIST_W + 1)'(PI_MRAD);
    localparam logic signed [DIST_W:0]  K_2PI  = (DIST_W + 1)'(2 * PI_MRAD);

    odo_state_e r_state;
    odo_state_e w_next;
    logic       w_start;
    logic       w_upd;

    logic [TW-1:0]            r_timer;
    logic                     w_wrap;
    logic signed [CNT_W-1:0]  w_cnt_l;
    logic signed [CNT_W-1:0]  w_cnt_r;
    logic                     w_sat_l;
    logic                     w_sat_r;
    logic signed [CNT_W-1:0]  r_snap_l;
    logic signed [CNT_W-1:0]  r_snap_r;

    logic signed [DIV_W-1:0]  w_dl;
    logic signed [DIV_W-1:0]  w_dr;
    logic signed [DIV_W-1:0]  w_dividend;
    logic signed [DIV_W-1:0]  r_dl;
    logic signed [DIV_W-1:0]  r_dr;
    logic                     w_div_done;
    logic signed [DIV_W-1:0]  w_quo;
    logic signed [DIV_W-1:0]  w_dth_q;
    logic signed [DIST_W-1:0] w_dth;
    logic signed [DIST_W:0]   w_t;
    logic signed [DIST_W-1:0] w_theta_n;
    logic signed [DIV_W:0]    w_sum;

    logic signed [DIST_W-1:0] r_o_dl;
    logic signed [DIST_W-1:0] r_o_dr;
    logic signed [DIST_W-1:0] r_o_avg;
    logic signed [DIST_W-1:0] r_o_dth;
    logic signed [DIST_W-1:0] r_theta;
    logic                     r_valid;
    logic                     r_ovf;

    assign w_wrap = enable && (r_timer == T_LAST);

    wheel_edge_decoder #(
        .CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .INVERT(INVERT_LEFT)
    ) u_left (
        .clk(clk), .reset(reset), .i_a(A_left), .i_b(B_left),
        .i_enable(enable), .i_wrap(w_wrap),
        .o_count(w_cnt_l), .o_sat(w_sat_l)
    );

    wheel_edge_decoder #(
        .CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INVERT(0)
    ) u_right (
        .clk(clk), .reset(reset), .i_a(A_right), .i_b(B_right),
        .i_enable(enable), .i_wrap(w_wrap),
        .o_count(w_cnt_r), .o_sat(w_sat_r)
    );

    // window timer, frozen while enable is low
    always_ff @(posedge clk) begin
        if (reset)       r_timer <= '0;
        else if (w_wrap) r_timer <= '0;
        else if (enable) r_timer <= r_timer + TW'(1);
    end

    // snapshot both counts at the window wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap_l <= '0;
            r_snap_r <= '0;
        end else if (w_wrap) begin
            r_snap_l <= w_cnt_l;
            r_snap_r <= w_cnt_r;
        end
    end

    // control state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // next state and one-cycle control strobes
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_upd   = 1'b0;
        unique case (r_state)
            IDLE:   if (w_wrap) w_next = LATCH;
            LATCH: begin
                w_start = 1'b1;
                w_next  = DIVIDE;
            end
            DIVIDE: if (w_div_done) w_next = UPDATE;
            UPDATE: begin
                w_upd  = 1'b1;
                w_next = IDLE;
            end
        endcase
    end

    assign w_dl = DIV_W'(r_snap_l) * K_DPP;
    assign w_dr = DIV_W'(r_snap_r) * K_DPP;
    assign w_dividend = (w_dr - w_dl) * K_MRAD;

    // hold the full-precision distances for the update step
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dl <= '0;
            r_dr <= '0;
        end else if (w_start) begin
            r_dl <= w_dl;
            r_dr <= w_dr;
        end
    end

    seq_signed_divider #(.DIV_W(DIV_W)) u_div (
        .clk(clk), .reset(reset), .i_start(w_start),
        .i_dividend(w_dividend), .i_divisor(K_WB),
        .o_done(w_div_done), .o_quotient(w_quo)
    );

    assign w_dth_q = (w_quo > K_PI_Q)  ? K_PI_Q :
                     (w_quo < -K_PI_Q) ? -K_PI_Q : w_quo;
    assign w_dth = DIST_W'(w_dth_q);
    assign w_t = (DIST_W + 1)'(r_theta) + (DIST_W + 1)'(w_dth);
    assign w_theta_n = (w_t >= K_PI_T)  ? DIST_W'(w_t - K_2PI) :
                       (w_t < -K_PI_T)  ? DIST_W'(w_t + K_2PI) :
                                          DIST_W'(w_t);
    assign w_sum = (DIV_W + 1)'(r_dl) + (DIV_W + 1)'(r_dr);

    // result registers; clear_pose beats a coincident heading update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_o_dl  <= '0;
            r_o_dr  <= '0;
            r_o_avg <= '0;
            r_o_dth <= '0;
            r_theta <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= w_upd;
            if (w_upd) begin
                r_o_dl  <= DIST_W'(r_dl);
                r_o_dr  <= DIST_W'(r_dr);
                r_o_avg <= DIST_W'(w_sum >>> 1);
                r_o_dth <= w_dth;
            end
            if (clear_pose) r_theta <= '0;
            else if (w_upd) r_theta <= w_theta_n;
            if (clear_pose)             r_ovf <= 1'b0;
            else if (w_sat_l | w_sat_r) r_ovf <= 1'b1;
        end
    end

    assign o_odom.delta_left       = r_o_dl;
    assign o_odom.delta_right      = r_o_dr;
    assign o_odom.average_distance = r_o_avg;
    assign o_odom.delta_theta      = r_o_dth;
    assign o_odom.theta            = r_theta;
    assign o_odom.odom_valid       = r_valid;
    assign o_odom.busy             = (r_state != IDLE);
    assign o_odom.overflow         = r_ovf;

endmodule
